parking_gate_ctrl: RTL
======================

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 The module SHALL have one clock, clk, and a synchronous active-high reset, rst.
REQ-002 Port list (name  direction  width  meaning):
  clk  in  1  system clock, all logic on rising edge
  rst  in  1  synchronous active-high reset
  entry_detect  in  1  loop sensor, car waiting at entry barrier
  entry_uni_badge  in  1  university badge presented at entry
  entry_passed  in  1  beam sensor, car cleared entry barrier
  exit_detect  in  1  loop sensor, car waiting at exit barrier
  exit_uni_badge  in  1  university badge presented at exit
  exit_passed  in  1  beam sensor, car cleared exit barrier
  is_vacated_space  in  1  general space free (from parking counter)
  uni_is_vacated_space  in  1  university space free (from parking counter)
  car_entered  out  1  one-cycle entry event to parking counter
  is_uni_car_entered  out  1  class of entry event, valid with car_entered
  car_exited  out  1  one-cycle exit event to parking counter
  is_uni_car_exited  out  1  class of exit event, valid with car_exited
  entry_barrier_open  out  1  entry barrier actuator
  exit_barrier_open  out  1  exit barrier actuator
  entry_reject  out  1  "lot full" lamp at entry
  gate_timeout  out  1  one-cycle pulse, either barrier timed out
REQ-003 Parameters (name, default, meaning): OPEN_TIMEOUT, 16, cycles a barrier stays open without a pass; REJECT_CYCLES, 4, cycles entry_reject stays lit.

Function
REQ-004 All outputs SHALL be registered.
REQ-005 Entry FSM states SHALL be IDLE, CHECK, OPEN, REJECT, WAIT_CLEAR.
REQ-006 In IDLE, entry_detect=1 SHALL latch entry_uni_badge and move to CHECK.
REQ-007 CHECK SHALL move to OPEN if the latched class has vacancy (uni: uni_is_vacated_space, else is_vacated_space), otherwise to REJECT.
REQ-008 entry_barrier_open SHALL be 1 exactly while in OPEN; first high cycle is 2 cycles after entry_detect is sampled.
REQ-009 In OPEN, entry_passed=1 SHALL produce car_entered=1 for exactly one cycle on the next edge, with is_uni_car_entered = latched class, then go to WAIT_CLEAR.
REQ-010 In OPEN, OPEN_TIMEOUT cycles without entry_passed SHALL pulse gate_timeout for one cycle, emit no event and go to WAIT_CLEAR.
REQ-011 REJECT SHALL hold entry_reject=1 for REJECT_CYCLES cycles, then go to WAIT_CLEAR.
REQ-012 WAIT_CLEAR SHALL return to IDLE only on the first cycle entry_detect=0; one detect assertion SHALL yield at most one event.
REQ-013 Exit FSM SHALL use the same states without the vacancy check: CHECK always goes to OPEN; REJECT is unreachable.
REQ-014 car_entered and car_exited SHALL never be high in the same cycle; entry has priority and a coincident exit event SHALL be held in a one-deep pending register and issued the next cycle with its class preserved.
REQ-015 is_uni_car_entered/is_uni_car_exited SHALL be 0 whenever their strobe is 0.
REQ-016 Vacancy inputs SHALL be sampled only in CHECK; later changes SHALL NOT close an open barrier.
REQ-017 Simultaneous entry and exit timeouts SHALL produce a single gate_timeout pulse.

Reset
REQ-018 While rst=1, both FSMs SHALL be IDLE, timers and pending register cleared, all outputs 0.
REQ-019 rst asserted mid-operation (barrier open, event pending) SHALL drop barriers and discard pending events with no strobe emitted.

Structure
REQ-020 Package parking_pkg SHALL hold the gate state enumeration and default OPEN_TIMEOUT/REJECT_CYCLES constants.
REQ-021 One sub-module, parking_gate_fsm (parameter CHECK_VACANCY), SHALL be instanced for entry (1) and exit (0); the top holds strobe arbitration and the pending register.

Verification
REQ-022 General car, is_vacated_space=1, entry_passed 3 cycles after open -> barrier high 3 cycles, car_entered pulse 1 cycle, is_uni_car_entered=0.
REQ-023 Uni badge, uni_is_vacated_space=0 -> entry_reject high 4 cycles, barrier never opens, no car_entered.
REQ-024 Exit opened, no exit_passed -> barrier closes after 16 cycles, gate_timeout single pulse, no car_exited.
REQ-025 entry_passed and exit_passed (uni) on same cycle -> car_entered at T+1, car_exited with is_uni_car_exited=1 at T+2.
REQ-026 entry_detect held 50 cycles through pass -> exactly one car_entered; rst while entry OPEN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parking_pkg
// Description : Shared gate state encoding, default timing constants and the
//               vacancy-selection helper for the parking gate controller.
// Revision    : 1.0 - initial release
// ============================================================================
package parking_pkg;

    localparam int c_open_timeout  = 16;
    localparam int c_reject_cycles = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CHECK      = 3'd1,
        ST_OPEN       = 3'd2,
        ST_REJECT     = 3'd3,
        ST_WAIT_CLEAR = 3'd4
    } gate_state_t;

    function automatic logic gate_has_vacancy(input logic uni,
                                              input logic vac_gen,
                                              input logic vac_uni);
        return uni ? vac_uni : vac_gen;
    endfunction

endpackage
`default_nettype wire

// File: rtl/parking_gate_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : parking_gate_ctrl_if
// Description : Sensor, actuator and counter-event signals of the parking
//               gate controller. master = controller, slave = environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface parking_gate_ctrl_if;

    logic entry_detect;
    logic entry_uni_badge;
    logic entry_passed;
    logic exit_detect;
    logic exit_uni_badge;
    logic exit_passed;
    logic is_vacated_space;
    logic uni_is_vacated_space;
    logic car_entered;
    logic is_uni_car_entered;
    logic car_exited;
    logic is_uni_car_exited;
    logic entry_barrier_open;
    logic exit_barrier_open;
    logic entry_reject;
    logic gate_timeout;

    modport master (
        input  entry_detect, entry_uni_badge, entry_passed,
        input  exit_detect, exit_uni_badge, exit_passed,
        input  is_vacated_space, uni_is_vacated_space,
        output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        output entry_barrier_open, exit_barrier_open, entry_reject, gate_timeout
    );

    modport slave (
        output entry_detect, entry_uni_badge, entry_passed,
        output exit_detect, exit_uni_badge, exit_passed,
        output is_vacated_space, uni_is_vacated_space,
        input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        input  entry_barrier_open, exit_barrier_open, entry_reject, gate_timeout
    );

endinterface
`default_nettype wire

// File: rtl/parking_gate_fsm.sv
`default_nettype none
// ============================================================================
// Module      : parking_gate_fsm
// Description : One barrier sequencer (detect, vacancy check, open, reject,
//               wait for the car to leave the loop). Used for entry and exit.
// Revision    : 1.0 - initial release
// ============================================================================
module parking_gate_fsm
    import parking_pkg::*;
#(
    parameter bit CHECK_VACANCY = 1'b1,
    parameter int OPEN_TIMEOUT  = c_open_timeout,
    parameter int REJECT_CYCLES = c_reject_cycles
) (
    input  wire  clk,
    input  wire  rst,
    input  logic i_detect,
    input  logic i_badge,
    input  logic i_passed,
    input  logic i_vac_gen,
    input  logic i_vac_uni,
    output logic o_event,
    output logic o_event_uni,
    output logic o_timeout,
    output logic o_barrier_open,
    output logic o_reject
);

    localparam int c_tmr_max = (OPEN_TIMEOUT > REJECT_CYCLES) ? OPEN_TIMEOUT : REJECT_CYCLES;
    localparam int c_tmr_w   = $clog2(c_tmr_max + 1);
    localparam logic [c_tmr_w-1:0] c_open_last   = c_tmr_w'(OPEN_TIMEOUT - 1);
    localparam logic [c_tmr_w-1:0] c_reject_last = c_tmr_w'(REJECT_CYCLES - 1);

    gate_state_t        r_state;
    gate_state_t        w_next;
    logic [c_tmr_w-1:0] r_timer;
    logic               r_uni;
    logic               w_vacant;
    logic               w_barrier_nxt;
    logic               w_reject_nxt;

    // Exit side never refuses a car, so its vacancy inputs are ignored.
    assign w_vacant = (CHECK_VACANCY == 1'b0) || gate_has_vacancy(r_uni, i_vac_gen, i_vac_uni);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_timer        <= '0;
            r_uni          <= 1'b0;
            o_barrier_open <= 1'b0;
            o_reject       <= 1'b0;
        end else begin
            r_state        <= w_next;
            o_barrier_open <= w_barrier_nxt;
            o_reject       <= w_reject_nxt;
            if (w_next != r_state) begin
                r_timer <= '0;
            end else if (r_state == ST_OPEN || r_state == ST_REJECT) begin
                r_timer <= r_timer + 1'b1;
            end
            if (r_state == ST_IDLE && i_detect) begin
                r_uni <= i_badge;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:       if (i_detect) w_next = ST_CHECK;
            ST_CHECK:      w_next = w_vacant ? ST_OPEN : ST_REJECT;
            ST_OPEN:       if (i_passed || r_timer == c_open_last) w_next = ST_WAIT_CLEAR;
            ST_REJECT:     if (r_timer == c_reject_last) w_next = ST_WAIT_CLEAR;
            ST_WAIT_CLEAR: if (!i_detect) w_next = ST_IDLE;
            default:       w_next = ST_IDLE;
        endcase
    end

    // Level outputs are registered from the next state so they track the state exactly.
    always_comb begin
        w_barrier_nxt = (w_next == ST_OPEN);
        w_reject_nxt  = (w_next == ST_REJECT);
        o_event       = (r_state == ST_OPEN) && i_passed;
        o_event_uni   = o_event && r_uni;
        o_timeout     = (r_state == ST_OPEN) && !i_passed && (r_timer == c_open_last);
    end

endmodule
`default_nettype wire

// File: rtl/parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : parking_gate_ctrl
// Description : Entry/exit barrier controller with serialised event strobes
//               towards the parking space counter.
// Revision    : 1.0 - initial release
// ============================================================================
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int OPEN_TIMEOUT  = c_open_timeout,
    parameter int REJECT_CYCLES = c_reject_cycles
) (
    input  wire                 clk,
    input  wire                 rst,
    parking_gate_ctrl_if.master gate
);

    logic w_entry_evt, w_entry_uni, w_entry_to, w_entry_open, w_entry_reject;
    logic w_exit_evt, w_exit_uni, w_exit_to, w_exit_open, w_exit_reject_unused;

    logic r_car_entered, r_uni_entered;
    logic r_car_exited, r_uni_exited;
    logic r_timeout;
    logic r_pending, r_pending_uni;

    parking_gate_fsm #(
        .CHECK_VACANCY (1'b1),
        .OPEN_TIMEOUT  (OPEN_TIMEOUT),
        .REJECT_CYCLES (REJECT_CYCLES)
    ) u_entry (
        .clk            (clk),
        .rst            (rst),
        .i_detect       (gate.entry_detect),
        .i_badge        (gate.entry_uni_badge),
        .i_passed       (gate.entry_passed),
        .i_vac_gen      (gate.is_vacated_space),
        .i_vac_uni      (gate.uni_is_vacated_space),
        .o_event        (w_entry_evt),
        .o_event_uni    (w_entry_uni),
        .o_timeout      (w_entry_to),
        .o_barrier_open (w_entry_open),
        .o_reject       (w_entry_reject)
    );

    parking_gate_fsm #(
        .CHECK_VACANCY (1'b0),
        .OPEN_TIMEOUT  (OPEN_TIMEOUT),
        .REJECT_CYCLES (REJECT_CYCLES)
    ) u_exit (
        .clk            (clk),
        .rst            (rst),
        .i_detect       (gate.exit_detect),
        .i_badge        (gate.exit_uni_badge),
        .i_passed       (gate.exit_passed),
        .i_vac_gen      (1'b0),
        .i_vac_uni      (1'b0),
        .o_event        (w_exit_evt),
        .o_event_uni    (w_exit_uni),
        .o_timeout      (w_exit_to),
        .o_barrier_open (w_exit_open),
        .o_reject       (w_exit_reject_unused)
    );

    // Entry wins a collision; the exit event waits one cycle in the pending slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_car_entered <= 1'b0;
            r_uni_entered <= 1'b0;
            r_car_exited  <= 1'b0;
            r_uni_exited  <= 1'b0;
            r_timeout     <= 1'b0;
            r_pending     <= 1'b0;
            r_pending_uni <= 1'b0;
        end else begin
            r_car_entered <= w_entry_evt;
            r_uni_entered <= w_entry_evt & w_entry_uni;
            r_timeout     <= w_entry_to | w_exit_to;
            if (w_entry_evt) begin
                r_car_exited <= 1'b0;
                r_uni_exited <= 1'b0;
                if (w_exit_evt && !r_pending) begin
                    r_pending     <= 1'b1;
                    r_pending_uni <= w_exit_uni;
                end
            end else if (r_pending) begin
                r_car_exited  <= 1'b1;
                r_uni_exited  <= r_pending_uni;
                r_pending     <= w_exit_evt;
                r_pending_uni <= w_exit_evt & w_exit_uni;
            end else begin
                r_car_exited <= w_exit_evt;
                r_uni_exited <= w_exit_evt & w_exit_uni;
            end
        end
    end

    assign gate.car_entered        = r_car_entered;
    assign gate.is_uni_car_entered = r_uni_entered;
    assign gate.car_exited         = r_car_exited;
    assign gate.is_uni_car_exited  = r_uni_exited;
    assign gate.entry_barrier_open = w_entry_open;
    assign gate.exit_barrier_open  = w_exit_open;
    assign gate.entry_reject       = w_entry_reject;
    assign gate.gate_timeout       = r_timeout;

endmodule
`default_nettype wire
